// File: rtl/led_pkg.sv
// Purpose: shared types and helpers for the 8x8x4-bit LED frame RAM write side.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package led_pkg;

  localparam int LED_ROWS   = 8;
  localparam int LED_COLS   = 8;
  localparam int LED_POS_W  = 6;
  localparam int LED_DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DWELL   = 3'd1,
    SETUP   = 3'd2,
    WE_HIGH = 3'd3,
    HOLD    = 3'd4
  } led_state_e;

  // 3-bit index to 8-bit one-hot row/column select.
  function automatic logic [7:0] bin_to_onehot(input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'd1 << idx;
    return oh;
  endfunction

endpackage

// File: rtl/pen_hit_scanner_pen_sync.sv
// Purpose: 2-FF synchroniser for the light pen plus saturating run-of-highs counter.
// Latency: hit asserts 2+HIT_MIN cycles after pen_in rises (with sample_en held high).
// Backpressure: none; the counter simply holds at 0 while sample_en is low.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pen_in          raw asynchronous sensor input
//   clear           zero the run counter this cycle (position change)
//   sample_en       count only while high; counter held at 0 otherwise
//   hit             run counter has reached HIT_MIN
module pen_sync #(
  parameter int HIT_MIN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pen_in,
  input  logic clear,
  input  logic sample_en,
  output logic hit
);

  localparam int RW = $clog2(HIT_MIN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(HIT_MIN);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);

  logic          meta_q;
  logic          sync_q;
  logic [RW-1:0] run_q;
  logic [RW-1:0] run_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      run_q  <= '0;
    end else begin
      meta_q <= pen_in;
      sync_q <= meta_q;
      run_q  <= run_d;
    end
  end

  // Any low sample, a clear, or being outside the sample window restarts the run.
  always_comb begin
    run_d = '0;
    if (!clear && sample_en && sync_q) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
    end
  end

  assign hit = (run_q == RUN_MAX);

endmodule

// File: rtl/pen_hit_scanner.sv
// Purpose: raster-scan the LED matrix, detect light-pen hits, drive one clean RAM write per hit.
// Latency: write seq = 1 setup cycle, WE_LEN cycles of we, 2 hold cycles; then next position.
// Backpressure: none; enable low parks the scan (a write in flight always completes first).
//
// Ports: clk, rst_n (async active-low); enable (level); pen_in (async sensor); pen_data[3:0];
//   scan_row/scan_col one-hot probe drive (0 when idle); addr_row/addr_col/data RAM write
//   address and data (held between hits); we write pulse; frame_done 1-cycle pulse after p=63.
// Optional macro PEN_HIT_DEDUP_EN: skip a write whose position and data equal the last write.
module pen_hit_scanner
  import led_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int SETTLE   = 200,
  parameter int HIT_MIN  = 8,
  parameter int WE_LEN   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  pen_in,
  input  logic [LED_DATA_W-1:0] pen_data,
  output logic [LED_ROWS-1:0]   scan_row,
  output logic [LED_COLS-1:0]   scan_col,
  output logic [LED_ROWS-1:0]   addr_row,
  output logic [LED_COLS-1:0]   addr_col,
  output logic [LED_DATA_W-1:0] data,
  output logic                  we,
  output logic                  frame_done
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(WE_LEN + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] SETTLE_CNT = DW'(SETTLE);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [CW-1:0] WE_LAST    = CW'(WE_LEN - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  led_state_e             state_q, state_d;
  logic [LED_POS_W-1:0]   p_q, p_d;
  logic [DW-1:0]          dwell_q, dwell_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LED_ROWS-1:0]    addr_row_q, addr_row_d;
  logic [LED_COLS-1:0]    addr_col_q, addr_col_d;
  logic [LED_DATA_W-1:0]  data_q, data_d;
  logic                   we_q, we_d;
  logic                   frame_done_q, frame_done_d;
  logic                   advance;
  logic                   sync_clear;
  logic                   sample_en;
  logic                   pen_hit;
  logic                   dup_hit;

  assign sample_en = (state_q == DWELL) && (dwell_q >= SETTLE_CNT);

  pen_sync #(
    .HIT_MIN (HIT_MIN)
  ) u_pen_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .pen_in    (pen_in),
    .clear     (sync_clear),
    .sample_en (sample_en),
    .hit       (pen_hit)
  );

`ifdef PEN_HIT_DEDUP_EN
  logic                  last_vld_q, last_vld_d;
  logic [LED_POS_W-1:0]  last_p_q, last_p_d;
  logic [LED_DATA_W-1:0] last_data_q, last_data_d;

  assign dup_hit = last_vld_q && (last_p_q == p_q) && (last_data_q == pen_data);

  // SETUP is only ever entered on a real (non-duplicate) write, so it marks the record point.
  always_comb begin
    last_vld_d  = last_vld_q;
    last_p_d    = last_p_q;
    last_data_d = last_data_q;
    if (state_d == SETUP) begin
      last_vld_d  = 1'b1;
      last_p_d    = p_q;
      last_data_d = pen_data;
    end
    if (!enable) begin
      last_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_vld_q  <= 1'b0;
      last_p_q    <= '0;
      last_data_q <= '0;
    end else begin
      last_vld_q  <= last_vld_d;
      last_p_q    <= last_p_d;
      last_data_q <= last_data_d;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    addr_row_d = addr_row_q;
    addr_col_d = addr_col_q;
    data_d     = data_q;
    advance    = 1'b0;
    sync_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = DWELL;
          dwell_d    = '0;
          sync_clear = 1'b1;
        end
      end
      DWELL: begin
        // A hit on the final dwell cycle still wins over advancing.
        if (!enable) begin
          state_d = IDLE;
        end else if (pen_hit) begin
          if (dup_hit) begin
            advance = 1'b1;
          end else begin
            addr_row_d = bin_to_onehot(p_q[5:3]);
            addr_col_d = bin_to_onehot(p_q[2:0]);
            data_d     = pen_data;
            state_d    = SETUP;
          end
        end else if (dwell_q == DWELL_LAST) begin
          advance = 1'b1;
        end else begin
          dwell_d = dwell_q + DWELL_ONE;
        end
      end
      SETUP: begin
        state_d = WE_HIGH;
        cnt_d   = '0;
      end
      WE_HIGH: begin
        if (cnt_q == WE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        // Position advances even when parking, so re-enable resumes past the written LED.
        if (cnt_q == HOLD_LAST) begin
          advance = 1'b1;
          state_d = enable ? DWELL : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (advance) begin
      p_d        = p_q + 6'd1;
      dwell_d    = '0;
      sync_clear = 1'b1;
    end
    frame_done_d = advance && (&p_q);
    // Registered from the next state so we is a clean flop output.
    we_d = (state_d == WE_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      p_q          <= '0;
      dwell_q      <= '0;
      cnt_q        <= '0;
      addr_row_q   <= '0;
      addr_col_q   <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      dwell_q      <= dwell_d;
      cnt_q        <= cnt_d;
      addr_row_q   <= addr_row_d;
      addr_col_q   <= addr_col_d;
      data_q       <= data_d;
      we_q         <= we_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign scan_row   = (state_q == IDLE) ? '0 : bin_to_onehot(p_q[5:3]);
  assign scan_col   = (state_q == IDLE) ? '0 : bin_to_onehot(p_q[2:0]);
  assign addr_row   = addr_row_q;
  assign addr_col   = addr_col_q;
  assign data       = data_q;
  assign we         = we_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pen_hit_scanner.sv
module tb_pen_hit_scanner;

  localparam int SCAN_DIV = 16;
  localparam int SETTLE   = 4;
  localparam int HIT_MIN  = 3;
  localparam int WE_LEN   = 4;
`ifdef PEN_HIT_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       pen_in = 1'b0;
  logic [3:0] pen_data = 4'h0;
  logic [7:0] scan_row, scan_col, addr_row, addr_col;
  logic [3:0] data;
  logic       we, frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pen_hit_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .SETTLE   (SETTLE),
    .HIT_MIN  (HIT_MIN),
    .WE_LEN   (WE_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pen_in     (pen_in),
    .pen_data   (pen_data),
    .scan_row   (scan_row),
    .scan_col   (scan_col),
    .addr_row   (addr_row),
    .addr_col   (addr_col),
    .data       (data),
    .we         (we),
    .frame_done (frame_done)
  );

  // Reference model: scan position, time within dwell, run of qualified samples,
  // and the offset into the write sequence (-1 when no write is in progress).
  bit         m_act, m_has, m_fd, m_s1, m_s2, m_lv;
  int         m_p, m_t, m_run, m_wt, m_ap, m_lp;
  logic [3:0] m_data, m_ld;

  task automatic model_reset();
    m_act = 0; m_has = 0; m_fd = 0; m_s1 = 0; m_s2 = 0; m_lv = 0;
    m_p = 0; m_t = 0; m_run = 0; m_wt = -1; m_ap = 0; m_lp = 0;
    m_data = 4'h0; m_ld = 4'h0;
  endtask

  task automatic model_step();
    bit samp;
    bit adv;
    samp = m_s2;
    m_s2 = m_s1;
    m_s1 = pen_in;
    m_fd = 0;
    adv  = 0;
    if (m_wt >= 0) begin
      // Sequence: offset 0 setup, 1..WE_LEN we high, then two hold cycles.
      if (m_wt == WE_LEN + 2) begin
        adv = 1; m_act = enable; m_wt = -1;
      end else begin
        m_wt++;
      end
      m_run = 0;
    end else if (!m_act) begin
      if (enable) begin m_act = 1; m_t = 0; end
      m_run = 0;
    end else if (!enable) begin
      m_act = 0; m_run = 0;
    end else if (m_run >= HIT_MIN) begin
      if (DEDUP && m_lv && m_lp == m_p && m_ld == pen_data) begin
        adv = 1;
      end else begin
        m_wt = 0; m_has = 1; m_ap = m_p; m_data = pen_data;
        m_lv = 1; m_lp = m_p; m_ld = pen_data;
      end
      m_run = 0;
    end else if (m_t == SCAN_DIV - 1) begin
      adv = 1;
    end else begin
      m_run = (m_t >= SETTLE && samp) ? ((m_run + 1 > HIT_MIN) ? HIT_MIN : m_run + 1) : 0;
      m_t++;
    end
    if (adv) begin
      m_fd = (m_p == 63); m_p = (m_p + 1) % 64; m_t = 0; m_run = 0;
    end
    if (!enable) m_lv = 0;
  endtask

  function automatic logic [37:0] model_out();
    logic [7:0] one;
    logic [7:0] sr, sc, ar, ac;
    logic       w;
    one = 8'd1;
    sr = m_act ? (one << (m_p / 8)) : 8'h00;
    sc = m_act ? (one << (m_p % 8)) : 8'h00;
    ar = m_has ? (one << (m_ap / 8)) : 8'h00;
    ac = m_has ? (one << (m_ap % 8)) : 8'h00;
    w  = (m_wt >= 1 && m_wt <= WE_LEN);
    return {sr, sc, ar, ac, m_data, w, m_fd};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    check("cycle_outputs", {scan_row, scan_col, addr_row, addr_col, data, we, frame_done}, model_out());
  endtask

  task automatic do_reset();
    rst_n = 0; enable = 0; pen_in = 0; pen_data = 4'h0;
    model_reset();
    repeat (3) tick();
    rst_n = 1;
    tick();
  endtask

  typedef struct {
    int         pos;
    int         off;
    int         len;
    logic [3:0] pd;
    int         exp_w;
    logic [7:0] exp_r;
    logic [7:0] exp_c;
    logic [3:0] exp_d;
  } vec_t;

  vec_t vt[8];

  initial begin
    int writes, we_cyc, fd_cnt, fd_at, wc, burst, off_cnt;
    bit prev_we, seen;
    logic [7:0] cap_r, cap_c;
    logic [3:0] cap_d;

    vt[0] = '{10,  0, 16, 4'hA, 1, 8'h02, 8'h04, 4'hA};
    vt[1] = '{ 5,  4,  2, 4'h3, 0, 8'h00, 8'h00, 4'h0};
    vt[2] = '{ 5,  4,  3, 4'h7, 1, 8'h01, 8'h20, 4'h7};
    vt[3] = '{20,  0,  4, 4'h9, 0, 8'h00, 8'h00, 4'h0};
    vt[4] = '{20,  0,  5, 4'h9, 1, 8'h04, 8'h10, 4'h9};
    vt[5] = '{ 3, 11,  3, 4'h6, 0, 8'h00, 8'h00, 4'h0};
    vt[6] = '{ 3, 10,  3, 4'h6, 1, 8'h01, 8'h08, 4'h6};
    vt[7] = '{63,  0, 16, 4'hF, 1, 8'h80, 8'h80, 4'hF};

    // Reset state.
    do_reset();
    check("reset_outputs", {scan_row, scan_col, addr_row, addr_col, data, we, frame_done}, 38'h0);

    // Full frame with no pen.
    enable = 1; fd_cnt = 0; fd_at = 0; writes = 0;
    for (int k = 0; k < 1100; k++) begin
      tick();
      if (frame_done) begin fd_cnt++; fd_at = k + 1; end
      if (we) writes++;
      if (k == 16)  check("scan_p1",  {scan_row, scan_col}, 16'h0102);
      if (k == 128) check("scan_p8",  {scan_row, scan_col}, 16'h0201);
    end
    check("frame_done_count", fd_cnt, 1);
    check("frame_done_cycle", fd_at, 1 + 64 * SCAN_DIV);
    check("no_pen_we", writes, 0);

    // Table of single-position pen pulses.
    foreach (vt[i]) begin
      int start, stop, total;
      do_reset();
      enable = 1; pen_data = vt[i].pd;
      start = 1 + SCAN_DIV * vt[i].pos + vt[i].off;
      stop  = start + vt[i].len;
      total = 1 + SCAN_DIV * (vt[i].pos + 2) + 16;
      writes = 0; we_cyc = 0; prev_we = 0;
      cap_r = 8'h00; cap_c = 8'h00; cap_d = 4'h0;
      for (int k = 0; k < total; k++) begin
        pen_in = (k >= start && k < stop);
        tick();
        if (we && !prev_we) begin writes++; cap_r = addr_row; cap_c = addr_col; cap_d = data; end
        if (we) we_cyc++;
        prev_we = we;
      end
      pen_in = 0;
      check($sformatf("vec%0d_writes", i), writes, vt[i].exp_w);
      check($sformatf("vec%0d_we_cycles", i), we_cyc, vt[i].exp_w * WE_LEN);
      if (vt[i].exp_w > 0)
        check($sformatf("vec%0d_addr_data", i), {cap_r, cap_c, cap_d}, {vt[i].exp_r, vt[i].exp_c, vt[i].exp_d});
    end

    // Enable dropped on the second we-high cycle.
    do_reset();
    enable = 1; pen_data = 4'h3; seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      pen_in = (k >= 33 && k < 49);
      tick();
      if (we) seen = 1;
    end
    check("drop_we_seen", seen, 1);
    pen_in = 0; wc = 1;
    tick();
    if (we) wc++;
    enable = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (we) wc++;
    end
    check("drop_we_len", wc, WE_LEN);
    check("drop_idle_scan", {scan_row, scan_col}, 16'h0000);
    enable = 1;
    tick();
    check("drop_resume_p3", {scan_row, scan_col}, 16'h0108);

    // Reset asserted mid write.
    do_reset();
    enable = 1; pen_data = 4'hB; seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      pen_in = (k >= 17 && k < 33);
      tick();
      if (we) seen = 1;
    end
    check("rst_we_seen", seen, 1);
    rst_n = 0; pen_in = 0;
    #1;
    model_reset();
    check("rst_mid_we", {scan_row, scan_col, addr_row, addr_col, data, we, frame_done}, 38'h0);
    tick();
    rst_n = 1;
    tick();
    check("rst_restart_p0", {scan_row, scan_col}, 16'h0101);

    // Randomized pen bursts, data and enable drops against the model.
    do_reset();
    enable = 1; burst = 0; off_cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      if (burst > 0) burst--;
      else if ($urandom_range(0, 19) == 0) burst = $urandom_range(1, 8);
      if (off_cnt > 0) off_cnt--;
      else if ($urandom_range(0, 299) == 0) off_cnt = $urandom_range(1, 20);
      pen_in   = (burst > 0);
      enable   = (off_cnt == 0);
      pen_data = 4'($urandom_range(0, 15));
      tick();
    end
    pen_in = 0; enable = 1;

    // Same position hit over three frames; data changes on the third.
    do_reset();
    enable = 1; fd_cnt = 0; writes = 0; prev_we = 0;
    for (int k = 0; k < 3400 && fd_cnt < 3; k++) begin
      pen_in   = (m_p == 9);
      pen_data = (fd_cnt >= 2) ? 4'h5 : 4'hC;
      tick();
      if (frame_done) fd_cnt++;
      if (we && !prev_we) writes++;
      prev_we = we;
    end
    pen_in = 0;
    check("dedup_frames", fd_cnt, 3);
    check("dedup_writes", writes, DEDUP ? 2 : 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pen_hit_scanner.md
Name: pen_hit_scanner

Overview:
- Upstream write-side stage for the 8x8x4-bit LED frame RAM.
- Raster-scans the matrix one LED at a time and samples the synchronised light-pen sensor at each position.
- On a confirmed hit, presents the one-hot row/col address plus a 4-bit colour and generates a clean write-enable pulse.
- The RAM latches on the rising edge of `we` and commits on the falling edge, so address and data stay stable across the whole pulse.

Parameters:
- SCAN_DIV, 1000: cycles spent at each scan position (dwell) when no hit occurs; must be greater than SETTLE+HIT_MIN.
- SETTLE, 200: cycles after a position change before sampling starts (LED/sensor settling).
- HIT_MIN, 8: consecutive high synchronised samples required to declare a hit.
- WE_LEN, 4: width of the `we` pulse in cycles; minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scan enable (level)
- pen_in  in  1  raw light-pen sensor, asynchronous, active high
- pen_data  in  4  colour/intensity written on a hit
- scan_row  out  8  one-hot row drive for the probe LED
- scan_col  out  8  one-hot column drive for the probe LED
- addr_row  out  8  one-hot write row address to the RAM
- addr_col  out  8  one-hot write column address to the RAM
- data  out  4  write data to the RAM
- we  out  1  write enable pulse to the RAM
- frame_done  out  1  single-cycle pulse after position 63 completes

Behaviour:
- Reset (async): state IDLE, position 0. All outputs are 0: `scan_row`, `scan_col`, `addr_row`, `addr_col`, `data`, `we`, `frame_done`.
- `pen_in` passes through a 2-FF synchroniser; the run counter saturates at HIT_MIN. Detection latency from a `pen_in` rise is 2+HIT_MIN cycles.
- Position index p runs 0..63: row = p[5:3], col = p[2:0], so the column advances fastest. Advancing from 63 wraps to 0 and pulses `frame_done` for 1 cycle.
- IDLE:
  - Scan outputs are 0.
  - When `enable`=1, go to DWELL, drive `scan_row`/`scan_col` for p, and clear `dwell_cnt` and the run counter.
- DWELL:
  - `dwell_cnt` counts 0..SCAN_DIV-1.
  - The run counter is active only while `dwell_cnt` >= SETTLE; it is held at 0 before that and resets on any low sample.
  - When the run counter reaches HIT_MIN, register `addr_row`/`addr_col` (one-hot of p) and `data`=`pen_data`, then go to SETUP.
  - If `dwell_cnt` reaches SCAN_DIV-1 with no hit, advance p and stay in DWELL.
- SETUP: 1 cycle with `we`=0; address and data are already valid. Then go to WE_HIGH.
- WE_HIGH: `we`=1 for exactly WE_LEN cycles, then go to HOLD.
- HOLD: `we`=0 for 2 cycles with address and data unchanged, then advance p and go to DWELL.
- At most one write per position per frame. The rest of the dwell is abandoned after a hit.
- `addr_row`, `addr_col` and `data` keep their last values until the next hit. They are never changed while `we`=1 or during HOLD.
- `enable` falls:
  - In DWELL: go to IDLE next cycle. p is retained, so scanning resumes at the same position.
  - In SETUP, WE_HIGH or HOLD: complete the write sequence first, then go to IDLE. The RAM must see a falling edge.
- `pen_in` glitches shorter than HIT_MIN cycles never cause a write.
- A `pen_in` high that starts before SETTLE counts only from the first cycle where `dwell_cnt` >= SETTLE.
- `pen_data` is sampled only on the hit cycle.

Optional Feature:
- Macro: PEN_HIT_DEDUP_EN.
- Defined: hold the last written position and data. A hit whose position and `pen_data` both equal the last write goes straight to advancing p, with no SETUP, `we` or HOLD. The record clears on reset and whenever `enable` falls.
- Undefined: every qualified hit writes.

Decomposition:
- Shared package `led_pkg`:
  - LED_ROWS=8, LED_COLS=8, LED_POS_W=6, LED_DATA_W=4.
  - State enum: IDLE, DWELL, SETUP, WE_HIGH, HOLD.
  - Function `bin_to_onehot` (3→8).
- One sub-module, `pen_sync`: 2-FF synchroniser plus saturating consecutive-high counter, with `clear` and `sample_en` inputs and a `hit` output.

Test Plan (SCAN_DIV=16, SETTLE=4, HIT_MIN=3, WE_LEN=4):
- No pen, `enable`=1 for 1024 cycles → `scan_col` steps every 16 cycles in order 0x01..0x80, then `scan_row` advances; `frame_done` pulses once at cycle 1024; `we` stays 0.
- `pen_in` high only while p=10 → `addr_row`=0x02, `addr_col`=0x04, `data`=`pen_data`=0xA valid 1 cycle before `we`; `we` high exactly 4 cycles; address and data stable 2 cycles after `we` falls; p=11 starts next.
- 2-cycle `pen_in` pulse after settle → no `we`; a 3-cycle pulse → one write.
- `enable` dropped on the 2nd `we`-high cycle → `we` still completes 4 cycles, HOLD completes, then IDLE with scan outputs 0; re-enable resumes at the next position.
- `rst_n` asserted mid-WE_HIGH → all outputs 0 immediately; after release with `enable`=1, scanning restarts at p=0.
- PEN_HIT_DEDUP_EN: same position and data hit on two frames → exactly one `we` pulse; changing `pen_data` to 0x5 on the third frame → a second write.
